ps2_host_cmd: RTL and testbench

Host-to-device command controller for the PS/2 keyboard port. It accepts one command byte at a time from a requester, for example LED update ED/xx or reset FF. It takes ownership of the open-drain PS2_CLK/PS2_DAT lines, serialises the byte on device-generated clocks, and checks the device line-ack bit. It then waits for the acknowledge byte (FA) from the existing receive path, retrying on resend (FE), NACK or timeout. It sits beside the PS/2 receiver and gates it with `rx_inhibit` while transmitting.

---
 rtl/ps2_host_cmd_if.sv | 41 ++++
 rtl/ps2_host_cmd.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ps2_host_cmd.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_host_cmd_if.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_cmd_if
//  Purpose  : Bundle of the requester handshake, receiver side-band and the
//             open-drain PS/2 line signals used by ps2_host_cmd.
//  Revision : 1.0  initial release
// ============================================================================
interface ps2_host_cmd_if;
    // Requester command handshake and result
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       cmd_ready;
    logic       done;
    logic       err;
    logic [7:0] resp;
    logic       busy;

    // Side-band to/from the existing PS/2 receive path
    logic       rx_inhibit;
    logic       rx_valid;
    logic [7:0] rx_byte;

    // Raw open-drain line levels and pull-down enables
    logic       ps2_clk_in;
    logic       ps2_dat_in;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;

    // Controller view
    modport slave (
        input  cmd_valid, cmd_byte, rx_valid, rx_byte, ps2_clk_in, ps2_dat_in,
        output cmd_ready, done, err, resp, busy, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );

    // Requester / environment view
    modport master (
        output cmd_valid, cmd_byte, rx_valid, rx_byte, ps2_clk_in, ps2_dat_in,
        input  cmd_ready, done, err, resp, busy, rx_inhibit, ps2_clk_oe, ps2_dat_oe
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_cmd.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_host_cmd
//  Purpose  : PS/2 host-to-device command transmitter. Inhibits the bus,
//             issues request-to-send, shifts a byte out on device clocks,
//             checks the line-ack and waits for FA, retrying on FE, NACK or
//             timeout.
//  Revision : 1.0  initial release
// ============================================================================
module ps2_host_cmd #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRY      = 2,
    parameter int FILTER_LEN     = 8
) (
    input  logic           CLOCK_50,
    input  logic           clr,
    ps2_host_cmd_if.slave  bus
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int FLT_W = (FILTER_LEN > 1)     ? $clog2(FILTER_LEN)     : 1;
    localparam int RTY_W = (MAX_RETRY > 0)      ? $clog2(MAX_RETRY + 1)  : 1;

    localparam logic [INH_W-1:0] c_inh_last  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  c_to_last   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] c_flt_last  = FLT_W'(FILTER_LEN - 1);
    localparam logic [RTY_W-1:0] c_max_retry = RTY_W'(MAX_RETRY);
    localparam logic [7:0]       c_ack_byte  = 8'hFA;
    localparam logic [7:0]       c_rsnd_byte = 8'hFE;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_RTS       = 3'd2,
        ST_TX        = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_RESP = 3'd5,
        ST_RETRY     = 3'd6
    } state_t;

    // Line conditioning
    logic             clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
    logic             dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
    logic             clk_flt_q, clk_flt_d, dat_flt_q, dat_flt_d;
    logic [FLT_W-1:0] clk_cnt_q, clk_cnt_d, dat_cnt_q, dat_cnt_d;
    logic             clk_flip;
    logic             clk_fall;

    // Control path
    state_t           state_q, state_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [7:0]       byte_q, byte_d;
    logic             par_q, par_d;
    logic [7:0]       last_q, last_d;
    logic [7:0]       resp_q, resp_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             clk_oe_q, clk_oe_d;
    logic             dat_oe_q, dat_oe_d;
    logic             timeout;

    // Two-flop synchronisers for the asynchronous raw line levels
    always_comb begin
        clk_meta_d = bus.ps2_clk_in;
        clk_sync_d = clk_meta_q;
        dat_meta_d = bus.ps2_dat_in;
        dat_sync_d = dat_meta_q;
    end

    // Glitch filters: a level change needs FILTER_LEN consecutive differing samples
    always_comb begin
        clk_flt_d = clk_flt_q;
        clk_cnt_d = '0;
        clk_flip  = 1'b0;
        if (clk_sync_q != clk_flt_q) begin
            if (clk_cnt_q == c_flt_last) begin
                clk_flip  = 1'b1;
                clk_flt_d = clk_sync_q;
            end else begin
                clk_cnt_d = clk_cnt_q + 1'b1;
            end
        end
        dat_flt_d = dat_flt_q;
        dat_cnt_d = '0;
        if (dat_sync_q != dat_flt_q) begin
            if (dat_cnt_q == c_flt_last) begin
                dat_flt_d = dat_sync_q;
            end else begin
                dat_cnt_d = dat_cnt_q + 1'b1;
            end
        end
        // Falling edge is acted on in the same edge the filtered level drops
        clk_fall = clk_flip & clk_flt_q;
    end

    // Next-state, counters and line drive for the command sequencer
    always_comb begin
        state_d   = state_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        bit_idx_d = bit_idx_q;
        retry_d   = retry_q;
        byte_d    = byte_q;
        par_d     = par_q;
        last_d    = last_q;
        resp_d    = resp_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;

        // Per-attempt timer saturates so a deferred timeout still fires
        timeout = (to_cnt_q == c_to_last);
        if ((state_q == ST_TX || state_q == ST_ACK || state_q == ST_WAIT_RESP) && !timeout) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (bus.cmd_valid && bus.cmd_ready) begin
                    byte_d    = bus.cmd_byte;
                    par_d     = ~^bus.cmd_byte;
                    retry_d   = '0;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                if (inh_cnt_q == c_inh_last) begin
                    dat_oe_d = 1'b1;
                    state_d  = ST_RTS;
                end else begin
                    inh_cnt_d = inh_cnt_q + 1'b1;
                end
            end
            ST_RTS: begin
                // Data already held low as the start bit; hand the clock to the device
                clk_oe_d  = 1'b0;
                to_cnt_d  = '0;
                bit_idx_d = 4'd0;
                state_d   = ST_TX;
            end
            ST_TX: begin
                if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    last_d   = 8'h00;
                    state_d  = ST_RETRY;
                end else if (clk_fall) begin
                    if (bit_idx_q < 4'd8) begin
                        dat_oe_d = ~byte_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        dat_oe_d = ~par_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = ST_ACK;
                    end
                    bit_idx_d = bit_idx_q + 4'd1;
                end
            end
            ST_ACK: begin
                if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    last_d   = 8'h00;
                    state_d  = ST_RETRY;
                end else if (clk_fall) begin
                    if (!dat_flt_q) begin
                        state_d = ST_WAIT_RESP;
                    end else begin
                        last_d  = 8'h00;
                        state_d = ST_RETRY;
                    end
                end
            end
            ST_WAIT_RESP: begin
                // A byte strobe takes priority over a same-cycle timeout
                if (bus.rx_valid) begin
                    if (bus.rx_byte == c_ack_byte) begin
                        done_d  = 1'b1;
                        resp_d  = c_ack_byte;
                        state_d = ST_IDLE;
                    end else if (bus.rx_byte == c_rsnd_byte) begin
                        last_d  = c_rsnd_byte;
                        state_d = ST_RETRY;
                    end
                end else if (timeout) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    last_d   = 8'h00;
                    state_d  = ST_RETRY;
                end
            end
            ST_RETRY: begin
                if (retry_q < c_max_retry) begin
                    retry_d   = retry_q + 1'b1;
                    inh_cnt_d = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = ST_INHIBIT;
                end else begin
                    err_d   = 1'b1;
                    resp_d  = last_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLOCK_50) begin
        if (clr) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            clk_flt_q  <= 1'b1;
            dat_flt_q  <= 1'b1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
            state_q    <= ST_IDLE;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            bit_idx_q  <= 4'd0;
            retry_q    <= '0;
            byte_q     <= 8'h00;
            par_q      <= 1'b0;
            last_q     <= 8'h00;
            resp_q     <= 8'h00;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
        end else begin
            clk_meta_q <= clk_meta_d;
            clk_sync_q <= clk_sync_d;
            dat_meta_q <= dat_meta_d;
            dat_sync_q <= dat_sync_d;
            clk_flt_q  <= clk_flt_d;
            dat_flt_q  <= dat_flt_d;
            clk_cnt_q  <= clk_cnt_d;
            dat_cnt_q  <= dat_cnt_d;
            state_q    <= state_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            bit_idx_q  <= bit_idx_d;
            retry_q    <= retry_d;
            byte_q     <= byte_d;
            par_q      <= par_d;
            last_q     <= last_d;
            resp_q     <= resp_d;
            done_q     <= done_d;
            err_q      <= err_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
        end
    end

    // Ready only once the result pulse has been seen, so a requester
    // never overlaps a new command with the previous result
    assign bus.cmd_ready  = (state_q == ST_IDLE) && !done_q && !err_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.rx_inhibit = (state_q != ST_IDLE);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.resp       = resp_q;
    assign bus.ps2_clk_oe = clk_oe_q;
    assign bus.ps2_dat_oe = dat_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_cmd.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ps2_host_cmd
//  Purpose  : Directed bench for ps2_host_cmd with a PS/2 device model and a
//             result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ps2_host_cmd;

    localparam int INH      = 20;
    localparam int TO       = 2000;
    localparam int RETRIES  = 2;
    localparam int FLT      = 8;
    localparam int HALF     = 20;
    localparam int WAIT_MAX = 5000;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done = 0;
    int   n_err = 0;
    logic [9:0] exp_q[$];
    logic [9:0] mon_got;
    logic [9:0] mon_exp;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ps2_host_cmd_if bus();

    // Open-drain wired-AND of host and device pull-downs
    assign bus.ps2_clk_in = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_dat_in = ~(bus.ps2_dat_oe | dev_dat_low);

    ps2_host_cmd #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .MAX_RETRY     (RETRIES),
        .FILTER_LEN    (FLT)
    ) dut (
        .CLOCK_50(clk),
        .clr     (clr),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every done/err pulse pops one expected {done,err,resp}
    always @(negedge clk) begin
        if (!clr && (bus.done || bus.err)) begin
            if (bus.done) n_done++;
            if (bus.err)  n_err++;
            mon_got = {bus.done, bus.err, bus.resp};
            n_checks++;
            assert (exp_q.size() != 0) else begin
                n_errors++;
                $error("FAIL result_unexpected observed=%0h expected=none", mon_got);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                n_checks++;
                assert (mon_got === mon_exp) else begin
                    n_errors++;
                    $error("FAIL result observed=%0h expected=%0h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] b, input bit hold);
        int n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_byte  = b;
        while (!bus.cmd_ready && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", 32'(n < WAIT_MAX), 1);
        @(negedge clk);
        if (hold) bus.cmd_byte = 8'h55;
        else      bus.cmd_valid = 1'b0;
        check("accept_busy", {31'd0, bus.busy}, 1);
        check("accept_clk_oe", {31'd0, bus.ps2_clk_oe}, 1);
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", 32'(n < budget), 1);
    endtask

    task automatic wait_rts(output int t_rts);
        int n = 0;
        while (!(bus.ps2_clk_oe == 1'b0 && bus.ps2_dat_oe == 1'b1) && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        check("rts_seen", 32'(n < WAIT_MAX), 1);
        t_rts = cyc;
    endtask

    // Device: clocks out one frame, samples host data while clock is low,
    // optionally acks the line, optionally glitches the clock before pulse 4
    task automatic dev_frame(input bit nack, input bit glitch,
                             output logic [9:0] bits, output int t_rts);
        wait_rts(t_rts);
        bits = '0;
        tick(HALF);
        for (int p = 1; p <= 11; p++) begin
            if (glitch && p == 4) begin
                tick(5);
                dev_clk_low = 1'b1;
                tick(3);
                dev_clk_low = 1'b0;
                tick(5);
            end
            if (p == 11 && !nack) begin
                dev_dat_low = 1'b1;
                tick(HALF);
            end
            dev_clk_low = 1'b1;
            tick(HALF);
            if (p <= 10) bits[p-1] = ~(bus.ps2_dat_oe | dev_dat_low);
            dev_clk_low = 1'b0;
            tick(HALF);
        end
        dev_dat_low = 1'b0;
    endtask

    function automatic logic [9:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b};
    endfunction

    initial begin
        #10ms;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int t_rts;
        int n;
        bit seen;
        bus.cmd_valid = 1'b0;
        bus.cmd_byte  = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.rx_byte   = 8'h00;

        // Reset state
        tick(5);
        clr = 1'b0;
        tick(1);
        check("rst_ready", {31'd0, bus.cmd_ready}, 1);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_rxinh", {31'd0, bus.rx_inhibit}, 0);
        check("rst_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 0);
        check("rst_pulses", {30'd0, bus.done, bus.err}, 0);
        check("rst_resp", {24'd0, bus.resp}, 0);

        // ED, acked, FA; also checks inhibit length and RTS sequencing
        exp_q.push_back({1'b1, 1'b0, 8'hFA});
        send_cmd(8'hED, 1'b0);
        n = 0;
        while (bus.ps2_clk_oe && !bus.ps2_dat_oe && n < WAIT_MAX) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", n, INH);
        check("rts_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'b11);
        @(negedge clk);
        check("tx_oe", {30'd0, bus.ps2_clk_oe, bus.ps2_dat_oe}, 32'b01);
        dev_frame(1'b0, 1'b0, bits, t_rts);
        check("ed_frame", {22'd0, bits}, 32'b11_1110_1101);
        check("rxinh_busy", {30'd0, bus.rx_inhibit, bus.busy}, 32'b11);
        tick(5);
        send_rx(8'hFA);
        wait_idle(100);
        tick(2);
        check("ed_counts", {n_done[15:0], n_err[15:0]}, {16'd1, 16'd0});
        check("ed_ready_after", {30'd0, bus.cmd_ready, bus.busy}, 32'b10);

        // F4: resend once, stray FA while inhibiting, then FA
        exp_q.push_back({1'b1, 1'b0, 8'hFA});
        send_cmd(8'hF4, 1'b0);
        dev_frame(1'b0, 1'b0, bits, t_rts);
        check("f4_frame1", {22'd0, bits}, {22'd0, frame_of(8'hF4)});
        tick(5);
        send_rx(8'hFE);
        tick(3);
        send_rx(8'hFA);
        dev_frame(1'b0, 1'b0, bits, t_rts);
        check("f4_frame2", {22'd0, bits}, {22'd0, frame_of(8'hF4)});
        tick(5);
        send_rx(8'hFA);
        wait_idle(100);
        tick(2);
        check("f4_counts", {n_done[15:0], n_err[15:0]}, {16'd2, 16'd0});

        // FF: NACK on every attempt -> three attempts then err/00
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        send_cmd(8'hFF, 1'b0);
        for (int a = 0; a < 3; a++) begin
            dev_frame(1'b1, 1'b0, bits, t_rts);
            check("ff_frame", {22'd0, bits}, {22'd0, frame_of(8'hFF)});
        end
        wait_idle(200);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.ps2_clk_oe || bus.busy) seen = 1'b1;
        end
        check("ff_no_4th_attempt", {31'd0, seen}, 0);
        check("ff_counts", {n_done[15:0], n_err[15:0]}, {16'd2, 16'd1});

        // EE: line acked, no response (stray AA ignored) -> timeouts then err/00
        exp_q.push_back({1'b0, 1'b1, 8'h00});
        send_cmd(8'hEE, 1'b0);
        for (int a = 0; a < 3; a++) begin
            dev_frame(1'b0, 1'b0, bits, t_rts);
            check("ee_frame", {22'd0, bits}, {22'd0, frame_of(8'hEE)});
            if (a == 0) begin
                tick(5);
                send_rx(8'hAA);
            end
            if (a < 2) begin
                n = 0;
                while (!bus.ps2_clk_oe && n < TO + 200) begin
                    @(negedge clk);
                    n++;
                end
                check("ee_timeout_len", 32'((cyc - t_rts) >= TO - 1 && (cyc - t_rts) <= TO + 3), 1);
            end else begin
                wait_idle(TO + 200);
            end
        end
        tick(2);
        check("ee_counts", {n_done[15:0], n_err[15:0]}, {16'd2, 16'd2});

        // clr after bit 4 of ED: lines released next cycle, no result
        exp_q.push_back({1'b1, 1'b0, 8'hFA});
        send_cmd(8'hED, 1'b0);
        wait_rts(t_rts);
        tick(HALF);
        for (int p = 1; p <= 5; p++) begin
            dev_clk_low = 1'b1;
            tick(HALF);
            dev_clk_low = 1'b0;
            tick(HALF);
        end
        check("pre_clr_dat_oe", {31'd0, bus.ps2_dat_oe}, 1);
        clr = 1'b1;
        @(negedge clk);
        check("clr_release", {29'd0, bus.ps2_clk_oe, bus.ps2_dat_oe, bus.busy}, 0);
        exp_q.delete();
        tick(3);
        clr = 1'b0;
        tick(1);
        check("clr_ready", {31'd0, bus.cmd_ready}, 1);

        // ED again with clock glitch and cmd_valid held (byte changed) while busy
        exp_q.push_back({1'b1, 1'b0, 8'hFA});
        send_cmd(8'hED, 1'b1);
        dev_frame(1'b0, 1'b1, bits, t_rts);
        check("glitch_frame", {22'd0, bits}, 32'b11_1110_1101);
        check("ready_while_busy", {31'd0, bus.cmd_ready}, 0);
        tick(5);
        send_rx(8'hFA);
        wait_idle(100);
        bus.cmd_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.busy) seen = 1'b1;
        end
        check("no_extra_accept", {31'd0, seen}, 0);
        check("final_counts", {n_done[15:0], n_err[15:0]}, {16'd3, 16'd2});
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
